// File: rtl/branch_pkg.sv
// Shared types for branch execution units.
// Contents:
//   RS_XLEN / RS_ROB_W : datapath and ROB tag widths carried by rs_entry_t.
//   br_op_e            : 4-bit branch/jump opcode encoding.
//   OP_COND_MASK / OP_JUMP_MASK : one bit per opcode value, used for class decode.
//   rs_entry_t         : one reservation-station entry.
package branch_pkg;

  localparam int RS_XLEN  = 32;
  localparam int RS_ROB_W = 6;

  typedef enum logic [3:0] {
    OP_BEQ  = 4'b0000,
    OP_BNE  = 4'b0001,
    OP_BLT  = 4'b0100,
    OP_BGE  = 4'b0101,
    OP_BLTU = 4'b0110,
    OP_BGEU = 4'b0111,
    OP_JAL  = 4'b1000,
    OP_JALR = 4'b1001
  } br_op_e;

  // Bit n is set when opcode value n belongs to the class.
  localparam logic [15:0] OP_COND_MASK = 16'h00F3;
  localparam logic [15:0] OP_JUMP_MASK = 16'h0300;

  function automatic logic is_cond(input logic [3:0] op);
    return OP_COND_MASK[op];
  endfunction

  function automatic logic is_jump(input logic [3:0] op);
    return OP_JUMP_MASK[op];
  endfunction

  typedef struct packed {
    logic [3:0]          op;
    logic [RS_ROB_W-1:0] rob;
    logic                v1;
    logic [RS_ROB_W-1:0] tag1;
    logic [RS_XLEN-1:0]  op1;
    logic                v2;
    logic [RS_ROB_W-1:0] tag2;
    logic [RS_XLEN-1:0]  op2;
    logic [RS_XLEN-1:0]  pc;
    logic [RS_XLEN-1:0]  offset;
    logic [RS_XLEN-1:0]  pred_pc;
  } rs_entry_t;

endpackage

// File: rtl/exec_branch_rs_if.sv
// Dispatch / CDB-snoop / result bundle of the branch reservation station.
// master: dispatch + CDB side (drives flush, in_*, snoop_*, out_ready).
// slave : the branch unit (drives in_ready, out_*).
// Optional link outputs appear when EXEC_BRANCH_LINK_EN is defined.
interface exec_branch_rs_if #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 6
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [ROB_W-1:0] in_rob;
  logic             in_v1;
  logic             in_v2;
  logic [ROB_W-1:0] in_tag1;
  logic [ROB_W-1:0] in_tag2;
  logic [XLEN-1:0]  in_op1;
  logic [XLEN-1:0]  in_op2;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_offset;
  logic [XLEN-1:0]  in_pred_pc;
  logic             snoop_valid;
  logic [ROB_W-1:0] snoop_tag;
  logic [XLEN-1:0]  snoop_data;
  logic             out_valid;
  logic             out_ready;
  logic [ROB_W-1:0] out_rob;
  logic [XLEN-1:0]  out_next_pc;
  logic             out_taken;
  logic             out_mispredict;
`ifdef EXEC_BRANCH_LINK_EN
  logic [XLEN-1:0]  out_link;
  logic             out_link_valid;
`endif

  modport master (
    output flush, in_valid, in_op, in_rob, in_v1, in_v2, in_tag1, in_tag2,
           in_op1, in_op2, in_pc, in_offset, in_pred_pc,
           snoop_valid, snoop_tag, snoop_data, out_ready,
`ifdef EXEC_BRANCH_LINK_EN
    input  out_link, out_link_valid,
`endif
    input  in_ready, out_valid, out_rob, out_next_pc, out_taken, out_mispredict
  );

  modport slave (
    input  flush, in_valid, in_op, in_rob, in_v1, in_v2, in_tag1, in_tag2,
           in_op1, in_op2, in_pc, in_offset, in_pred_pc,
           snoop_valid, snoop_tag, snoop_data, out_ready,
`ifdef EXEC_BRANCH_LINK_EN
    output out_link, out_link_valid,
`endif
    output in_ready, out_valid, out_rob, out_next_pc, out_taken, out_mispredict
  );
endinterface

// File: rtl/branch_resolve.sv
// Purely combinational branch/jump resolution for one rs entry.
// Ports:
//   ent        in  : entry with both operands valid
//   next_pc    out : resolved next PC
//   taken      out : conditional taken, or any jump
//   mispredict out : next_pc differs from the entry's predicted PC
module branch_resolve
  import branch_pkg::*;
(
  input  rs_entry_t           ent,
  output logic [RS_XLEN-1:0]  next_pc,
  output logic                taken,
  output logic                mispredict
);
  logic [RS_XLEN-1:0] seq_pc;
  logic [RS_XLEN-1:0] tgt_pc;
  logic [RS_XLEN-1:0] jalr_pc;
  logic               cond;
  logic               unused_fields;

  // Bookkeeping fields are irrelevant to resolution.
  assign unused_fields = ^{ent.rob, ent.v1, ent.tag1, ent.v2, ent.tag2};

  assign seq_pc  = ent.pc + RS_XLEN'(4);
  assign tgt_pc  = ent.pc + ent.offset;
  assign jalr_pc = (ent.op1 + ent.offset) & ~RS_XLEN'(1);

  always_comb begin
    cond = 1'b0;
    case (ent.op)
      OP_BEQ:  cond = (ent.op1 == ent.op2);
      OP_BNE:  cond = (ent.op1 != ent.op2);
      OP_BLT:  cond = ($signed(ent.op1) <  $signed(ent.op2));
      OP_BGE:  cond = ($signed(ent.op1) >= $signed(ent.op2));
      OP_BLTU: cond = (ent.op1 <  ent.op2);
      OP_BGEU: cond = (ent.op1 >= ent.op2);
      default: cond = 1'b0;
    endcase
    taken   = is_jump(ent.op) | (is_cond(ent.op) & cond);
    next_pc = seq_pc;
    if (ent.op == OP_JALR)
      next_pc = jalr_pc;
    else if (taken)
      next_pc = tgt_pc;
    mispredict = (next_pc != ent.pred_pc);
  end
endmodule

// File: rtl/exec_branch_rs.sv
// Branch execution unit with an integrated DEPTH-entry reservation station.
// Entries capture missing operands from the CDB snoop, the oldest ready
// entry (age matrix) is resolved and written to a registered result stage
// with a valid/ready handshake toward the CDB arbiter.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : exec_branch_rs_if.slave (flush, dispatch, snoop, result)
// Optional: EXEC_BRANCH_LINK_EN adds out_link (pc+4) / out_link_valid.
module exec_branch_rs
  import branch_pkg::*;
#(
  parameter int XLEN  = RS_XLEN,
  parameter int DEPTH = 8,
  parameter int ROB_W = RS_ROB_W
) (
  input logic             clk,
  input logic             reset_n,
  exec_branch_rs_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // rs_entry_t widths are fixed by the package.
  if (XLEN != RS_XLEN || ROB_W != RS_ROB_W || DEPTH < 2) begin : g_param_check
    $error("exec_branch_rs: XLEN/ROB_W must match branch_pkg and DEPTH must be >= 2");
  end

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] age [DEPTH];   // age[i][j] = 1: entry i is older than j
  rs_entry_t        ent   [DEPTH];
  rs_entry_t        ent_w [DEPTH]; // entries after this cycle's wakeup
  logic [DEPTH-1:0] rdy;

  rs_entry_t        in_raw, in_ent, res_ent;
  logic             sel_hit, free_hit, blocked;
  logic [IW-1:0]    sel_idx, free_idx;
  logic             alloc_fire, issue_ok, issue_sel, issue_in, alloc_wr;

  logic [XLEN-1:0]  res_next_pc;
  logic             res_taken, res_mis;

  logic             out_valid_q, out_taken_q, out_mis_q;
  logic [ROB_W-1:0] out_rob_q;
  logic [XLEN-1:0]  out_next_pc_q;

  function automatic rs_entry_t wake(input rs_entry_t e, input logic sv,
                                     input logic [ROB_W-1:0] st,
                                     input logic [XLEN-1:0] sd);
    rs_entry_t r;
    r = e;
    if (sv && !e.v1 && e.tag1 == st) begin
      r.v1  = 1'b1;
      r.op1 = sd;
    end
    if (sv && !e.v2 && e.tag2 == st) begin
      r.v2  = 1'b1;
      r.op2 = sd;
    end
    return r;
  endfunction

  // Incoming op, with same-cycle CDB bypass on its operands.
  always_comb begin
    in_raw.op      = bus.in_op;
    in_raw.rob     = bus.in_rob;
    in_raw.v1      = bus.in_v1;
    in_raw.tag1    = bus.in_tag1;
    in_raw.op1     = bus.in_op1;
    in_raw.v2      = bus.in_v2;
    in_raw.tag2    = bus.in_tag2;
    in_raw.op2     = bus.in_op2;
    in_raw.pc      = bus.in_pc;
    in_raw.offset  = bus.in_offset;
    in_raw.pred_pc = bus.in_pred_pc;
    in_ent = wake(in_raw, bus.snoop_valid, bus.snoop_tag, bus.snoop_data);
  end

  // Wakeup is forwarded into readiness so an operand arriving this cycle
  // can issue on the same edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = busy[i] ? wake(ent[i], bus.snoop_valid, bus.snoop_tag, bus.snoop_data)
                         : ent[i];
      rdy[i]   = busy[i] & ent_w[i].v1 & ent_w[i].v2;
    end
  end

  // Oldest ready: a ready entry with no older ready entry.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    blocked = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        if (rdy[j] && age[j][i]) blocked = 1'b1;
      if (rdy[i] && !blocked) begin
        sel_hit = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  // Lowest-index free entry.
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
  end

  assign bus.in_ready = free_hit;

  assign alloc_fire = bus.in_valid && free_hit && !bus.flush;
  assign issue_ok   = (!out_valid_q || bus.out_ready) && !bus.flush;
  assign issue_sel  = issue_ok && sel_hit;
  // A ready op arriving with nothing older ready goes straight to the
  // result stage and never occupies an entry.
  assign issue_in   = issue_ok && !sel_hit && alloc_fire && in_ent.v1 && in_ent.v2;
  assign alloc_wr   = alloc_fire && !issue_in;
  assign res_ent    = sel_hit ? ent_w[sel_idx] : in_ent;

  branch_resolve u_resolve (
    .ent        (res_ent),
    .next_pc    (res_next_pc),
    .taken      (res_taken),
    .mispredict (res_mis)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (bus.flush) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (issue_sel && sel_idx == IW'(i)) busy[i] <= 1'b0;
      if (alloc_wr) begin
        busy[free_idx] <= 1'b1;
        // New entry is youngest: older than nobody, everyone older than it.
        for (int i = 0; i < DEPTH; i++) begin
          if (IW'(i) == free_idx) age[i] <= '0;
          else                    age[i][free_idx] <= 1'b1;
        end
      end
    end
  end

  // Payload needs no reset; busy qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent[i] <= ent_w[i];
    if (alloc_wr) ent[free_idx] <= in_ent;
  end

`ifdef EXEC_BRANCH_LINK_EN
  logic [XLEN-1:0] out_link_q;
  logic            out_link_valid_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_rob_q     <= '0;
      out_next_pc_q <= '0;
      out_taken_q   <= 1'b0;
      out_mis_q     <= 1'b0;
`ifdef EXEC_BRANCH_LINK_EN
      out_link_q       <= '0;
      out_link_valid_q <= 1'b0;
`endif
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (issue_sel || issue_in) begin
      out_valid_q   <= 1'b1;
      out_rob_q     <= res_ent.rob;
      out_next_pc_q <= res_next_pc;
      out_taken_q   <= res_taken;
      out_mis_q     <= res_mis;
`ifdef EXEC_BRANCH_LINK_EN
      out_link_q       <= res_ent.pc + XLEN'(4);
      out_link_valid_q <= is_jump(res_ent.op);
`endif
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_rob        = out_rob_q;
  assign bus.out_next_pc    = out_next_pc_q;
  assign bus.out_taken      = out_taken_q;
  assign bus.out_mispredict = out_mis_q;
`ifdef EXEC_BRANCH_LINK_EN
  assign bus.out_link       = out_link_q;
  assign bus.out_link_valid = out_link_valid_q;
`endif
endmodule

// File: tb/tb_exec_branch_rs.sv
// Directed bench for exec_branch_rs (DEPTH=8, XLEN=32, ROB_W=6).
module tb_exec_branch_rs;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  exec_branch_rs_if #(.XLEN(32), .ROB_W(6)) bus ();

  exec_branch_rs #(.XLEN(32), .DEPTH(8), .ROB_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [5:0] rob,
                      input logic v1, input logic [5:0] t1, input logic [31:0] a,
                      input logic v2, input logic [5:0] t2, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] off, input logic [31:0] pred);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rob     = rob;
    bus.in_v1      = v1;
    bus.in_tag1    = t1;
    bus.in_op1     = a;
    bus.in_v2      = v2;
    bus.in_tag2    = t2;
    bus.in_op2     = b;
    bus.in_pc      = pc;
    bus.in_offset  = off;
    bus.in_pred_pc = pred;
  endtask

  task automatic res(input string tag, input logic [5:0] rob, input logic [31:0] npc,
                     input logic tk, input logic mp);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".rob"},   32'(bus.out_rob), 32'(rob));
    chk({tag, ".npc"},   bus.out_next_pc, npc);
    chk({tag, ".taken"}, 32'(bus.out_taken), 32'(tk));
    chk({tag, ".mis"},   32'(bus.out_mispredict), 32'(mp));
  endtask

  initial begin
    reset_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 4'h0; bus.in_rob = '0; bus.in_v1 = 1'b0; bus.in_v2 = 1'b0;
    bus.in_tag1 = '0; bus.in_tag2 = '0; bus.in_op1 = '0; bus.in_op2 = '0;
    bus.in_pc = '0; bus.in_offset = '0; bus.in_pred_pc = '0;
    bus.snoop_valid = 1'b0; bus.snoop_tag = '0; bus.snoop_data = '0;
    bus.out_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.rob", 32'(bus.out_rob), 32'd0);
    chk("rst.npc", bus.out_next_pc, 32'd0);
    chk("rst.taken", 32'(bus.out_taken), 32'd0);
    chk("rst.mis", 32'(bus.out_mispredict), 32'd0);
    reset_n = 1'b1;
    tick();

    // BEQ taken, predicted fall-through
    disp(4'h0, 6'd1, 1, 0, 32'd5, 1, 0, 32'd5, 32'h100, 32'h20, 32'h104);
    tick();
    bus.in_valid = 1'b0;
    res("beq", 6'd1, 32'h120, 1, 1);
    tick();
    chk("beq.drain", 32'(bus.out_valid), 32'd0);

    // Signed vs unsigned compare, back to back
    disp(4'h4, 6'd2, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'd1, 32'h200, 32'h40, 32'h240);
    tick();
    res("blt", 6'd2, 32'h240, 1, 0);
    disp(4'h6, 6'd3, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'd1, 32'h200, 32'h40, 32'h240);
    tick();
    res("bltu", 6'd3, 32'h204, 0, 1);

    // Jumps and an undefined code
    disp(4'h9, 6'd4, 1, 0, 32'h1001, 1, 0, 32'd0, 32'h300, 32'd2, 32'h1002);
    tick();
    res("jalr", 6'd4, 32'h1002, 1, 0);
    disp(4'h8, 6'd5, 1, 0, 32'd0, 1, 0, 32'd0, 32'h400, 32'hFFFF_FFF0, 32'h404);
    tick();
    res("jal", 6'd5, 32'h3F0, 1, 1);
`ifdef EXEC_BRANCH_LINK_EN
    chk("jal.link", bus.out_link, 32'h404);
    chk("jal.link_valid", 32'(bus.out_link_valid), 32'd1);
`endif
    disp(4'h2, 6'd6, 1, 0, 32'd0, 1, 0, 32'd0, 32'h500, 32'h80, 32'h504);
    tick();
    res("undef", 6'd6, 32'h504, 0, 0);
    bus.in_valid = 1'b0;
    tick();

    // A waits on tag 3, B ready: B first, then A after wakeup
    disp(4'h1, 6'd10, 0, 6'd3, 32'd0, 1, 0, 32'd7, 32'h600, 32'h10, 32'h604);
    tick();
    chk("ageA.wait", 32'(bus.out_valid), 32'd0);
    disp(4'h0, 6'd11, 1, 0, 32'd1, 1, 0, 32'd2, 32'h700, 32'h10, 32'h704);
    tick();
    res("ageB", 6'd11, 32'h704, 0, 0);
    bus.in_valid = 1'b0;
    bus.snoop_valid = 1'b1; bus.snoop_tag = 6'd3; bus.snoop_data = 32'd7;
    tick();
    bus.snoop_valid = 1'b0;
    res("ageA", 6'd10, 32'h604, 0, 0);

    // Backpressure: older A2 woken while younger C waits; A2 wins
    disp(4'h0, 6'd12, 1, 0, 32'd1, 1, 0, 32'd1, 32'h800, 32'h8, 32'h808);
    tick();
    res("hold0", 6'd12, 32'h808, 1, 0);
    bus.out_ready = 1'b0;
    disp(4'h5, 6'd13, 0, 6'd5, 32'd0, 1, 0, 32'd1, 32'h900, 32'h10, 32'h910);
    tick();
    disp(4'h7, 6'd14, 1, 0, 32'hFFFF_FFFE, 1, 0, 32'd1, 32'hA00, 32'h100, 32'hB00);
    tick();
    bus.in_valid = 1'b0;
    bus.snoop_valid = 1'b1; bus.snoop_tag = 6'd5; bus.snoop_data = 32'hFFFF_FFFE;
    tick();
    bus.snoop_valid = 1'b0;
    res("hold1", 6'd12, 32'h808, 1, 0);
    bus.out_ready = 1'b1;
    tick();
    res("oldA2", 6'd13, 32'h904, 0, 1);
    tick();
    res("youngC", 6'd14, 32'hB00, 1, 0);
    tick();
    chk("c.drain", 32'(bus.out_valid), 32'd0);

    // Fill the station behind a stalled result, then flush
    bus.out_ready = 1'b0;
    disp(4'h0, 6'd19, 1, 0, 32'd0, 1, 0, 32'd0, 32'hD00, 32'h20, 32'hD20);
    tick();
    for (int k = 0; k < 8; k++) begin
      disp(4'h0, 6'(20 + k), 0, 6'd30, 32'd0, 1, 0, 32'd0, 32'hE00, 32'h4, 32'hE04);
      tick();
    end
    chk("full.in_ready", 32'(bus.in_ready), 32'd0);
    disp(4'h0, 6'd28, 1, 0, 32'd0, 1, 0, 32'd0, 32'hF00, 32'h4, 32'hF04);
    tick();
    bus.in_valid = 1'b0;
    chk("full.in_ready2", 32'(bus.in_ready), 32'd0);
    res("full.stable", 6'd19, 32'hD20, 1, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush.valid", 32'(bus.out_valid), 32'd0);
    chk("flush.in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    bus.snoop_valid = 1'b1; bus.snoop_tag = 6'd30; bus.snoop_data = 32'd0;
    tick();
    bus.snoop_valid = 1'b0;
    chk("flush.empty", 32'(bus.out_valid), 32'd0);

    // Operand captured from the CDB in the allocation cycle
    disp(4'h0, 6'd33, 1, 0, 32'd9, 0, 6'd7, 32'd0, 32'hC00, 32'h40, 32'hC04);
    bus.snoop_valid = 1'b1; bus.snoop_tag = 6'd7; bus.snoop_data = 32'd9;
    tick();
    bus.snoop_valid = 1'b0;
    bus.in_valid = 1'b0;
    res("bypass", 6'd33, 32'hC40, 1, 1);

    // Asynchronous reset mid-stream
    disp(4'h0, 6'd40, 1, 0, 32'd3, 1, 0, 32'd3, 32'h40, 32'h8, 32'h48);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("pre_rst.valid", 32'(bus.out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst.valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst.rob", 32'(bus.out_rob), 32'd0);
    chk("async_rst.npc", bus.out_next_pc, 32'd0);
    chk("async_rst.in_ready", 32'(bus.in_ready), 32'd1);
    #2 reset_n = 1'b1;
    tick();
    chk("post_rst.valid", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
